// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_pkg
//  Brief    : Shared widths, types and reset constant for the 5-to-32 decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    localparam int SEL_W  = 5;
    localparam int OUT_W  = 32;
    localparam int BANK_W = 8;
    localparam int BANK_N = OUT_W / BANK_W;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_W-1:0] onehot_t;

    // All-zero "no select" value held by the registered output during reset
    localparam onehot_t ONEHOT_RESET = 32'h0;

    // True only when exactly one bit is set; any X makes the result X,
    // which an if/else consumer resolves to "not one-hot".
    function automatic logic is_onehot(input onehot_t v);
        return (v != '0) && ((v & (v - onehot_t'(1))) == '0);
    endfunction

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decoder_3x8.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_3x8
//  Brief    : Pure-combinational 3-to-8 one-hot decoder (one bank).
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_3x8
    import decoder_pkg::*;
(
    input  logic [2:0]        sel,
    output logic [BANK_W-1:0] dec
);

    always_comb begin
        dec = 'x;
        case (sel)
            3'd0:    dec = 8'b0000_0001;
            3'd1:    dec = 8'b0000_0010;
            3'd2:    dec = 8'b0000_0100;
            3'd3:    dec = 8'b0000_1000;
            3'd4:    dec = 8'b0001_0000;
            3'd5:    dec = 8'b0010_0000;
            3'd6:    dec = 8'b0100_0000;
            3'd7:    dec = 8'b1000_0000;
            default: dec = 'x;
        endcase
    end

endmodule : decoder_3x8
`default_nettype wire

// File: rtl/decoder_5x32.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_5x32
//  Brief    : 5-to-32 one-hot decoder, combinational and registered outputs.
//             Optional one-hot checker: DECODER_5X32_ONEHOT_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_5x32
    import decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    output logic [OUT_W-1:0] result,
    input  logic [SEL_W-1:0] control,
    output logic [OUT_W-1:0] result_q
`ifdef DECODER_5X32_ONEHOT_CHECK_EN
    ,
    output logic             err_q
`endif
);

    logic [BANK_N-1:0] w_bank_en;
    onehot_t           w_tree;
    onehot_t           w_xmask;
    onehot_t           w_result;
    onehot_t           r_result;

    always_comb begin
        w_bank_en = 'x;
        case (control[4:3])
            2'd0:    w_bank_en = 4'b0001;
            2'd1:    w_bank_en = 4'b0010;
            2'd2:    w_bank_en = 4'b0100;
            2'd3:    w_bank_en = 4'b1000;
            default: w_bank_en = 'x;
        endcase
    end

    generate
        for (genvar k = 0; k < BANK_N; k++) begin : g_bank
            logic [BANK_W-1:0] w_dec;

            decoder_3x8 u_dec (
                .sel (control[2:0]),
                .dec (w_dec)
            );

            assign w_tree[k*BANK_W +: BANK_W] = {BANK_W{w_bank_en[k]}} & w_dec;
        end
    endgenerate

    // Logically zero; in simulation an unknown select bit turns it into X so
    // the AND-tree's zero bits cannot masquerade as a valid one-hot word.
    assign w_xmask  = {OUT_W{(^control) ^ (^control)}};
    assign w_result = w_tree ^ w_xmask;
    assign result   = w_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= ONEHOT_RESET;
        end else begin
            r_result <= w_result;
        end
    end

    assign result_q = r_result;

`ifdef DECODER_5X32_ONEHOT_CHECK_EN
    logic w_err;
    logic r_err;

    // if/else so an X from the one-hot test lands on the error branch
    always_comb begin
        w_err = 1'b1;
        if (is_onehot(w_result)) begin
            w_err = 1'b0;
        end else begin
            w_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err;
        end
    end

    assign err_q = r_err;
`endif

endmodule : decoder_5x32
`default_nettype wire

// File: tb/tb_decoder_5x32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_5x32
//  Brief    : Self-checking bench for decoder_5x32 against a shift-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_5x32;

    logic        clk;
    logic        rst_n;
    logic [31:0] result;
    logic [4:0]  control;
    logic [31:0] result_q;
`ifdef DECODER_5X32_ONEHOT_CHECK_EN
    logic        err_q;
`endif

    int n_cmp;
    int n_err;

    decoder_5x32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .result   (result),
        .control  (control),
        .result_q (result_q)
`ifdef DECODER_5X32_ONEHOT_CHECK_EN
        ,
        .err_q    (err_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bit number "control" set, or all-X for an unknown code
    function automatic logic [31:0] model(input logic [4:0] c);
        if ($isunknown(c)) return {32{1'bx}};
        return 32'h1 << c;
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        control = 5'd3;
        #2;
        n_cmp++;
        if (result_q !== 32'h0) begin
            n_err++;
            $display("FAIL reset_result_q: got %h want %h", result_q, 32'h0);
        end
        n_cmp++;
        if (result !== 32'h8) begin
            n_err++;
            $display("FAIL reset_result_comb: got %h want %h", result, 32'h8);
        end
`ifdef DECODER_5X32_ONEHOT_CHECK_EN
        n_cmp++;
        if (err_q !== 1'b0) begin
            n_err++;
            $display("FAIL reset_err_q: got %b want 0", err_q);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_comb_sweep();
        logic [4:0]  codes [11] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd7,
                                    5'd8, 5'd15, 5'd16, 5'd24, 5'd31};
        logic [31:0] want  [11] = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h80,
                                    32'h100, 32'h8000, 32'h1_0000, 32'h100_0000,
                                    32'h8000_0000};
        for (int i = 0; i < 11; i++) begin
            control = codes[i];
            #5;
            n_cmp++;
            if (result !== want[i]) begin
                n_err++;
                $display("FAIL comb_sweep ctl=%0d: got %h want %h", codes[i], result, want[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            control = 5'(i);
            #1;
            n_cmp++;
            if (result !== model(control) || $countones(result) != 1) begin
                n_err++;
                $display("FAIL exhaustive ctl=%0d: got %h want %h", i, result, model(control));
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (result_q !== model(control)) begin
                n_err++;
                $display("FAIL exhaustive_q ctl=%0d: got %h want %h", i, result_q, model(control));
            end
`ifdef DECODER_5X32_ONEHOT_CHECK_EN
            n_cmp++;
            if (err_q !== 1'b0) begin
                n_err++;
                $display("FAIL exhaustive_err ctl=%0d: got %b want 0", i, err_q);
            end
`endif
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        control = 5'd5;
        @(posedge clk);
        #1;
        n_cmp++;
        if (result_q !== 32'h20) begin
            n_err++;
            $display("FAIL latency_n: got %h want %h", result_q, 32'h20);
        end
        control = 5'd6;
        #1;
        n_cmp++;
        if (result !== 32'h40) begin
            n_err++;
            $display("FAIL latency_comb: got %h want %h", result, 32'h40);
        end
        n_cmp++;
        if (result_q !== 32'h20) begin
            n_err++;
            $display("FAIL latency_hold: got %h want %h", result_q, 32'h20);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (result_q !== 32'h40) begin
            n_err++;
            $display("FAIL latency_n1: got %h want %h", result_q, 32'h40);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        control = 5'd5;
        @(posedge clk);
        #1;
        n_cmp++;
        if (result_q !== 32'h20) begin
            n_err++;
            $display("FAIL arst_pre: got %h want %h", result_q, 32'h20);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (result_q !== 32'h0) begin
            n_err++;
            $display("FAIL arst_clear: got %h want %h", result_q, 32'h0);
        end
`ifdef DECODER_5X32_ONEHOT_CHECK_EN
        n_cmp++;
        if (err_q !== 1'b0) begin
            n_err++;
            $display("FAIL arst_err: got %b want 0", err_q);
        end
`endif
        control = 5'd9;
        #1;
        n_cmp++;
        if (result !== model(5'd9)) begin
            n_err++;
            $display("FAIL arst_comb_track: got %h want %h", result, model(5'd9));
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (result_q !== 32'h0) begin
            n_err++;
            $display("FAIL arst_held: got %h want %h", result_q, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (result_q !== model(5'd9)) begin
            n_err++;
            $display("FAIL arst_reload: got %h want %h", result_q, model(5'd9));
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] prev;
        @(negedge clk);
        prev    = 5'($urandom_range(0, 31));
        control = prev;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (result_q !== model(prev)) begin
                n_err++;
                $display("FAIL b2b_q[%0d] ctl=%0d: got %h want %h", i, prev, result_q, model(prev));
            end
            prev    = 5'($urandom_range(0, 31));
            control = prev;
            #1;
            n_cmp++;
            if (result !== model(prev)) begin
                n_err++;
                $display("FAIL b2b_comb[%0d] ctl=%0d: got %h want %h", i, prev, result, model(prev));
            end
        end
    endtask

    task automatic test_x_input();
        logic [31:0] want;
        @(negedge clk);
        control = 5'bx0000;
        #1;
        want = model(control);
        n_cmp++;
        if (result !== want) begin
            n_err++;
            $display("FAIL x_input_comb: got %h want %h", result, want);
        end
        @(posedge clk);
        #1;
`ifdef DECODER_5X32_ONEHOT_CHECK_EN
        n_cmp++;
        if (err_q !== ($isunknown(want) ? 1'b1 : 1'b0)) begin
            n_err++;
            $display("FAIL x_input_err: got %b want %b", err_q, $isunknown(want));
        end
`endif
        n_cmp++;
        if (result_q !== want) begin
            n_err++;
            $display("FAIL x_input_q: got %h want %h", result_q, want);
        end
        @(negedge clk);
        control = 5'd0;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        control = 5'd0;
        test_reset();
        test_comb_sweep();
        test_exhaustive();
        test_latency();
        test_async_reset();
        test_back_to_back();
        test_x_input();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_decoder_5x32
`default_nettype wire
